// File: rtl/pwm_bank.sv
// pwm_bank: bank of NUM_CH shadowed PWM channels sharing one prescaler and one period counter.
//
// Ports:
//   clk          single clock, all state updates on its rising edge
//   rst          synchronous active-high reset
//   ena          count enable; low freezes counters and forces pwm_out to 0
//   wr_valid     register write request, always accepted in the same cycle
//   wr_addr      register address: 0..NUM_CH-1 pending duty, NUM_CH enable mask,
//                NUM_CH+1 prescaler, anything else invalid
//   wr_data      write data (DUTY_W bits)
//   wr_ack       one-cycle pulse after a write to a valid address
//   wr_err       one-cycle pulse after a write to an invalid address
//   pwm_out      registered PWM outputs, one per channel
//   period_start one-cycle pulse after the period counter wraps
module pwm_bank #(
  parameter int unsigned NUM_CH  = 8,
  parameter int unsigned DUTY_W  = 8,
  parameter int unsigned PRESC_W = 4,
  parameter int unsigned ADDR_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DUTY_W-1:0] wr_data,
  output logic              wr_ack,
  output logic              wr_err,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              period_start
);

  localparam logic [ADDR_W-1:0] AddrEn    = ADDR_W'(NUM_CH);
  localparam logic [ADDR_W-1:0] AddrPresc = ADDR_W'(NUM_CH + 1);
  localparam logic [DUTY_W-1:0] DutyMax   = '1;

  logic [PRESC_W-1:0] pc_q, pc_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [DUTY_W-1:0]  cnt_q, cnt_d;
  logic [NUM_CH-1:0]  en_q, en_d;
  logic [DUTY_W-1:0]  pend_q [NUM_CH];
  logic [DUTY_W-1:0]  pend_d [NUM_CH];
  logic [DUTY_W-1:0]  act_q [NUM_CH];
  logic [DUTY_W-1:0]  act_d [NUM_CH];
  logic [NUM_CH-1:0]  pwm_q, pwm_d;
  logic               ack_q, ack_d;
  logic               err_q, err_d;
  logic               start_q, start_d;

  logic tick;
  logic wrap;

  assign tick = ena && (pc_q == presc_q);
  assign wrap = tick && (cnt_q == DutyMax);

  always_comb begin
    pc_d    = pc_q;
    presc_d = presc_q;
    cnt_d   = cnt_q;
    en_d    = en_q;
    pend_d  = pend_q;
    act_d   = act_q;
    pwm_d   = '0;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    start_d = 1'b0;

    if (ena) begin
      if (tick) begin
        pc_d  = '0;
        cnt_d = cnt_q + 1'b1;
      end else begin
        pc_d = pc_q + 1'b1;
      end
    end

    // Active duty loads the pending value as it stood before this edge, so a
    // duty write landing on the wrap edge waits for the next wrap.
    if (wrap) begin
      act_d   = pend_q;
      start_d = 1'b1;
    end

    // All-ones duty is forced high so full scale has no one-cycle dip at wrap.
    for (int i = 0; i < NUM_CH; i++) begin
      pwm_d[i] = ena && en_q[i] && ((act_q[i] == DutyMax) || (cnt_q < act_q[i]));
    end

    if (wr_valid) begin
      if (wr_addr < AddrEn) begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (wr_addr == ADDR_W'(i)) begin
            pend_d[i] = wr_data;
          end
        end
        ack_d = 1'b1;
      end else if (wr_addr == AddrEn) begin
        en_d  = wr_data[NUM_CH-1:0];
        ack_d = 1'b1;
      end else if (wr_addr == AddrPresc) begin
        // Clearing pc here overrides the count update above.
        presc_d = wr_data[PRESC_W-1:0];
        pc_d    = '0;
        ack_d   = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= '0;
      presc_q <= '0;
      cnt_q   <= '0;
      en_q    <= '0;
      pend_q  <= '{default: '0};
      act_q   <= '{default: '0};
      pwm_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      pend_q  <= pend_d;
      act_q   <= act_d;
      pwm_q   <= pwm_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      start_q <= start_d;
    end
  end

  assign pwm_out      = pwm_q;
  assign wr_ack       = ack_q;
  assign wr_err       = err_q;
  assign period_start = start_q;

endmodule
